// File: rtl/serial_parity_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | serial_parity_pkg                                                        |
// | Shared types and constants for the serial parity framer.                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package serial_parity_pkg;

  typedef enum logic [0:0] {
    ST_DATA = 1'b0,
    ST_PAR  = 1'b1
  } state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int FRAME_CNT_W = 16;

endpackage
`default_nettype wire

// File: rtl/parity_out_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | parity_out_reg                                                           |
// | One-deep valid/ready output register with a slot-free indication.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module parity_out_reg (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic load_bit,
  input  logic load_is_par,
  input  logic out_ready,
  output logic out_valid,
  output logic out_bit,
  output logic out_is_par,
  output logic slot_free
);

  assign slot_free = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_bit    <= 1'b0;
      out_is_par <= 1'b0;
    end else if (load) begin
      out_valid  <= 1'b1;
      out_bit    <= load_bit;
      out_is_par <= load_is_par;
    end else if (out_valid && out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/serial_parity_framer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | serial_parity_framer                                                     |
// | Frames a serial bit stream and inserts a parity bit after each frame.   |
// | Optional frame counter enabled by SERIAL_PARITY_FRAME_CNT_EN.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module serial_parity_framer
  import serial_parity_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int CNT_W     = $clog2(DATA_BITS)
) (
  input  logic clk,
  input  logic reset,
  input  logic odd_mode,
  input  logic in_valid,
  input  logic in_bit,
  output logic in_ready,
  output logic out_valid,
  output logic out_bit,
  output logic out_is_par,
  input  logic out_ready,
  output logic p,
  output logic frame_done
`ifdef SERIAL_PARITY_FRAME_CNT_EN
  ,
  input  logic                   cnt_clr,
  output logic [FRAME_CNT_W-1:0] frame_count
`endif
);

  localparam logic [CNT_W-1:0] c_last = CNT_W'(DATA_BITS - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_acc;
  logic             r_odd_q;

  logic w_slot_free;
  logic w_accept;
  logic w_par_load;
  logic w_par;

  assign in_ready   = (r_state == ST_DATA) && w_slot_free;
  assign w_accept   = in_valid && in_ready;
  assign w_par_load = (r_state == ST_PAR) && w_slot_free;
  assign w_par      = r_acc ^ r_odd_q;

  parity_out_reg u_out_reg (
    .clk         (clk),
    .reset       (reset),
    .load        (w_accept || w_par_load),
    .load_bit    (w_par_load ? w_par : in_bit),
    .load_is_par (w_par_load),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_bit     (out_bit),
    .out_is_par  (out_is_par),
    .slot_free   (w_slot_free)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_DATA;
      r_cnt      <= '0;
      r_acc      <= 1'b0;
      r_odd_q    <= PAR_EVEN;
      p          <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (r_state)
        ST_DATA: begin
          if (w_accept) begin
            // First bit of a frame latches the parity mode and restarts the XOR.
            if (r_cnt == '0) begin
              r_odd_q <= odd_mode;
              r_acc   <= in_bit;
            end else begin
              r_acc   <= r_acc ^ in_bit;
            end
            if (r_cnt == c_last) begin
              r_cnt   <= '0;
              r_state <= ST_PAR;
            end else begin
              r_cnt   <= r_cnt + 1'b1;
            end
          end
        end
        ST_PAR: begin
          if (w_slot_free) begin
            p          <= w_par;
            frame_done <= 1'b1;
            r_acc      <= 1'b0;
            r_state    <= ST_DATA;
          end
        end
        default: r_state <= ST_DATA;
      endcase
    end
  end

`ifdef SERIAL_PARITY_FRAME_CNT_EN
  // A clear coinciding with a completed frame counts that frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_count <= '0;
    end else if (cnt_clr) begin
      frame_count <= frame_done ? FRAME_CNT_W'(1) : '0;
    end else if (frame_done && (frame_count != '1)) begin
      frame_count <= frame_count + 1'b1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_parity_framer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_serial_parity_framer                                                  |
// | Randomized bench with a queue-based frame/parity reference model.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_serial_parity_framer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Index 0: DATA_BITS=8 instance, index 1: DATA_BITS=5 instance.
  logic om[2], iv[2], ib[2], irdy[2], ov[2], ob[2], op[2], ordy[2], pp[2], fd[2];
`ifdef SERIAL_PARITY_FRAME_CNT_EN
  logic        clr[2];
  logic [15:0] fc[2];
  logic        clr_on_fd = 1'b0;
`endif

  serial_parity_framer #(.DATA_BITS(8)) dut8 (
    .clk(clk), .reset(reset), .odd_mode(om[0]), .in_valid(iv[0]), .in_bit(ib[0]),
    .in_ready(irdy[0]), .out_valid(ov[0]), .out_bit(ob[0]), .out_is_par(op[0]),
    .out_ready(ordy[0]), .p(pp[0]), .frame_done(fd[0])
`ifdef SERIAL_PARITY_FRAME_CNT_EN
    , .cnt_clr(clr[0]), .frame_count(fc[0])
`endif
  );

  serial_parity_framer #(.DATA_BITS(5)) dut5 (
    .clk(clk), .reset(reset), .odd_mode(om[1]), .in_valid(iv[1]), .in_bit(ib[1]),
    .in_ready(irdy[1]), .out_valid(ov[1]), .out_bit(ob[1]), .out_is_par(op[1]),
    .out_ready(ordy[1]), .p(pp[1]), .frame_done(fd[1])
`ifdef SERIAL_PARITY_FRAME_CNT_EN
    , .cnt_clr(clr[1]), .frame_count(fc[1])
`endif
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: expected output stream {is_par, bit} and expected p per frame.
  logic [1:0] exp_q[$];
  logic       par_q[$];
  int         fill;
  logic       fx, fmode;
  logic       stalled, st_bit, st_par;
  int         n_par_seen;

  function automatic void model_clear();
    exp_q.delete();
    par_q.delete();
    fill = 0;
    fx = 1'b0;
    fmode = 1'b0;
    stalled = 1'b0;
    n_par_seen = 0;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    for (int s = 0; s < 2; s++) begin
      iv[s] = 1'b0; ib[s] = 1'b0; om[s] = 1'b0; ordy[s] = 1'b1;
`ifdef SERIAL_PARITY_FRAME_CNT_EN
      clr[s] = 1'b0;
`endif
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  // One clock cycle on instance sel: drive, check outputs, update model.
  task automatic step(input int sel, input logic v, input logic b, input logic rdy,
                      input logic mode, output logic accepted);
    int nb;
    logic [1:0] e;
    logic par;
    nb = (sel == 1) ? 5 : 8;
    @(negedge clk);
    iv[sel] = v; ib[sel] = b; ordy[sel] = rdy; om[sel] = mode;
`ifdef SERIAL_PARITY_FRAME_CNT_EN
    clr[sel] = 1'b0;
`endif
    #1;
    if (stalled) begin
      n_chk++;
      if (ov[sel] !== 1'b1 || ob[sel] !== st_bit || op[sel] !== st_par) begin
        n_fail++;
        $display("FAIL stall_hold: got v=%b bit=%b par=%b, need v=1 bit=%b par=%b",
                 ov[sel], ob[sel], op[sel], st_bit, st_par);
      end
    end
    stalled = ov[sel] && !rdy;
    st_bit = ob[sel];
    st_par = op[sel];
    if (ov[sel] && rdy) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL out_extra: got bit=%b par=%b, need no output", ob[sel], op[sel]);
      end else begin
        e = exp_q.pop_front();
        if ({op[sel], ob[sel]} !== e) begin
          n_fail++;
          $display("FAIL out_stream: got par=%b bit=%b, need par=%b bit=%b",
                   op[sel], ob[sel], e[1], e[0]);
        end
        if (e[1]) n_par_seen++;
      end
    end
    if (fd[sel]) begin
      n_chk++;
      if (par_q.size() == 0) begin
        n_fail++;
        $display("FAIL frame_done_extra: got frame_done=1, need 0");
      end else begin
        par = par_q.pop_front();
        if (pp[sel] !== par || op[sel] !== 1'b1) begin
          n_fail++;
          $display("FAIL p_value: got p=%b out_is_par=%b, need p=%b out_is_par=1",
                   pp[sel], op[sel], par);
        end
      end
`ifdef SERIAL_PARITY_FRAME_CNT_EN
      if (clr_on_fd) clr[sel] = 1'b1;
`endif
    end
    accepted = v && irdy[sel];
    if (accepted) begin
      if (fill == 0) begin
        fmode = mode;
        fx = 1'b0;
      end
      fx = fx ^ b;
      fill++;
      exp_q.push_back({1'b0, b});
      if (fill == nb) begin
        exp_q.push_back({1'b1, fx ^ fmode});
        par_q.push_back(fx ^ fmode);
        fill = 0;
      end
    end
  endtask

  task automatic send_bit(input int sel, input logic b, input logic mode);
    logic acc;
    int k;
    k = 0;
    acc = 1'b0;
    while (!acc && k < 64) begin
      step(sel, 1'b1, b, 1'b1, mode, acc);
      k++;
    end
    if (!acc) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready=0 for 64 cycles, need acceptance");
    end
  endtask

  task automatic drain(input int sel);
    logic acc;
    int k;
    k = 0;
    while ((exp_q.size() != 0 || par_q.size() != 0) && k < 100) begin
      step(sel, 1'b0, 1'b0, 1'b1, 1'b0, acc);
      k++;
    end
    step(sel, 1'b0, 1'b0, 1'b1, 1'b0, acc);
    n_chk++;
    if (exp_q.size() != 0 || par_q.size() != 0 || ov[sel] !== 1'b0) begin
      n_fail++;
      $display("FAIL drain: got pending out=%0d frames=%0d valid=%b, need 0 0 0",
               exp_q.size(), par_q.size(), ov[sel]);
    end
    iv[sel] = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    for (int s = 0; s < 2; s++) begin
      n_chk++;
      if ({ov[s], ob[s], op[s], pp[s], fd[s], irdy[s]} !== 6'b000001) begin
        n_fail++;
        $display("FAIL reset_state[%0d]: got v/b/par/p/fd/rdy=%b%b%b%b%b%b, need 000001",
                 s, ov[s], ob[s], op[s], pp[s], fd[s], irdy[s]);
      end
    end
  endtask

  task automatic test_even();
    logic [7:0] d;
    d = 8'b1011_0010;
    do_reset();
    for (int i = 0; i < 8; i++) send_bit(0, d[i], 1'b0);
    drain(0);
    n_chk++;
    if (pp[0] !== 1'b0 || n_par_seen != 1) begin
      n_fail++;
      $display("FAIL even_frame: got p=%b parity_bits=%0d, need p=0 parity_bits=1", pp[0], n_par_seen);
    end
  endtask

  task automatic test_odd();
    logic [7:0] d;
    d = 8'b1011_0010;
    for (int i = 0; i < 8; i++) send_bit(0, d[i], 1'b1);
    drain(0);
    n_chk++;
    if (pp[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL odd_frame: got p=%b, need p=1", pp[0]);
    end
    d = 8'($urandom);
    for (int i = 0; i < 8; i++) send_bit(0, d[i], (i < 3) ? 1'b1 : 1'b0);
    drain(0);
  endtask

  task automatic test_backpressure();
    logic acc;
    int sent, k;
    logic [3:0] pat;
    logic b;
    pat = 4'b1001;
    do_reset();
    sent = 0;
    k = 0;
    b = 1'($urandom);
    while (sent < 24 && k < 400) begin
      step(0, 1'b1, b, pat[k % 4], 1'b0, acc);
      if (acc) begin
        sent++;
        b = 1'($urandom);
      end
      k++;
    end
    drain(0);
    n_chk++;
    if (n_par_seen != 3) begin
      n_fail++;
      $display("FAIL backpressure_frames: got %0d parity bits, need 3", n_par_seen);
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    for (int i = 0; i < 5; i++) send_bit(0, 1'($urandom), 1'b0);
    do_reset();
    #1;
    n_chk++;
    if (ov[0] !== 1'b0 || pp[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL midframe_reset: got valid=%b p=%b, need 0 0", ov[0], pp[0]);
    end
    for (int i = 0; i < 8; i++) send_bit(0, 1'b1, 1'b0);
    drain(0);
    n_chk++;
    if (pp[0] !== 1'b0 || n_par_seen != 1) begin
      n_fail++;
      $display("FAIL ff_frame: got p=%b parity_bits=%0d, need p=0 parity_bits=1", pp[0], n_par_seen);
    end
  endtask

  task automatic test_five_bit();
    do_reset();
    for (int i = 0; i < 20; i++) send_bit(1, 1'($urandom), 1'($urandom));
    drain(1);
    n_chk++;
    if (n_par_seen != 4) begin
      n_fail++;
      $display("FAIL five_bit_frames: got %0d parity bits, need 4", n_par_seen);
    end
  endtask

`ifdef SERIAL_PARITY_FRAME_CNT_EN
  task automatic test_frame_count();
    do_reset();
    @(negedge clk);
    dut8.frame_count = 16'hFFFE;
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < 8; i++) send_bit(0, 1'($urandom), 1'b0);
    drain(0);
    n_chk++;
    if (fc[0] !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL count_saturate: got %h, need ffff", fc[0]);
    end
    clr_on_fd = 1'b1;
    for (int i = 0; i < 8; i++) send_bit(0, 1'($urandom), 1'b0);
    drain(0);
    clr_on_fd = 1'b0;
    n_chk++;
    if (fc[0] !== 16'h0001) begin
      n_fail++;
      $display("FAIL count_clr_coincide: got %h, need 0001", fc[0]);
    end
  endtask
`endif

  initial begin
    model_clear();
    test_reset();
    test_even();
    test_odd();
    test_backpressure();
    test_reset_midframe();
    test_five_bit();
`ifdef SERIAL_PARITY_FRAME_CNT_EN
    test_frame_count();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
